// File: rtl/encoder_req_latch.sv
// encoder_req_latch
// Request capture stage in front of the 8-to-3 encoder. Each request line is
// synchronised and its rising edge is detected. The edge is then held as a
// sticky pending bit until it is cleared by index or by clr_all. Lost events
// (an edge on a bit that is already pending) are flagged in a sticky overflow
// vector. All outputs are registered.
module encoder_req_latch #(
    parameter int N    = 8,
    parameter int IW   = 3,
    parameter int SYNC = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  i_req,
    input  logic [N-1:0]  i_mask,
    input  logic          i_clr_valid,
    input  logic [IW-1:0] i_clr_idx,
    input  logic          i_clr_all,
    output logic [N-1:0]  o_pend,
    output logic          o_any_pend,
    output logic [N-1:0]  o_ovf
);

    logic [SYNC-1:0][N-1:0] r_sync;
    logic [N-1:0]           r_rp;
    logic [N-1:0]           r_pend;
    logic [N-1:0]           r_ovf;
    logic                   r_any_pend;

    logic [N-1:0]           w_rs;
    logic [N-1:0]           w_edge;
    logic [N-1:0]           w_clr_hit;
    logic [N-1:0]           w_pend_nxt;
    logic [N-1:0]           w_ovf_nxt;

    assign w_rs   = r_sync[SYNC-1];
    assign w_edge = w_rs & ~r_rp & i_mask;

    // Synchroniser chain for the asynchronous requests, plus the one-cycle delay used for edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_rp   <= '0;
        end else begin
            r_sync[0] <= i_req;
            for (int k = 1; k < SYNC; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_rp <= w_rs;
        end
    end

    // One-hot decode of the clear index; an index at or beyond N matches no bit and is ignored
    always_comb begin
        w_clr_hit = '0;
        for (int i = 0; i < N; i++) begin
            w_clr_hit[i] = i_clr_valid && (i_clr_idx == IW'(i));
        end
    end

    // Next-state of pending and overflow: clr_all first, then set, then clear by index, otherwise hold
    always_comb begin
        w_pend_nxt = r_pend;
        w_ovf_nxt  = r_ovf;
        if (i_clr_all) begin
            w_pend_nxt = '0;
            w_ovf_nxt  = '0;
        end else begin
            w_pend_nxt = w_edge | (r_pend & ~w_clr_hit);
            w_ovf_nxt  = r_ovf | (w_edge & r_pend & ~w_clr_hit);
        end
    end

    // Pending, overflow and any_pend registers; any_pend uses next-state pend so it lines up with o_pend
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend     <= '0;
            r_ovf      <= '0;
            r_any_pend <= 1'b0;
        end else begin
            r_pend     <= w_pend_nxt;
            r_ovf      <= w_ovf_nxt;
            r_any_pend <= |w_pend_nxt;
        end
    end

    assign o_pend     = r_pend;
    assign o_ovf      = r_ovf;
    assign o_any_pend = r_any_pend;

endmodule
